if_fetch: RTL and testbench

Instruction-fetch stage of the RISC-V pipeline: consumer of the PC register's output. Captures the current PC, reads the 32-bit instruction from the byte-wide memory controller as four sequential byte reads, assembles it little-endian, and presents `{inst, pc}` to the IF/ID latch. Drives `pc+4` back to the PC register and raises a stall request while a fetch is in flight. Honours branch flushes mid-fetch.

---
 rtl/if_fetch.sv | 155 +++++++++++++++
 tb/tb_if_fetch.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch.sv
// if_fetch: instruction-fetch stage. Reads four bytes per instruction
// from a byte-wide memory port and presents {inst, pc} to IF/ID.
//
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   stall[1:0]    stage control: 00 pass, 01/11 hold, 10 bubble
//   branch        taken-branch flush from EX
//   pc_i          current PC from the PC register
//   pc_next_o     fetch_pc + 4, back to the PC register
//   mem_req       level read request, held until mem_ack
//   mem_addr      byte address of the outstanding request
//   mem_ack       one-cycle strobe, mem_data valid with it
//   mem_data      returned byte
//   stall_req_o   high while a fetch is in flight or draining
//   inst_valid_o  inst_o / inst_pc_o hold a complete instruction
//   inst_o        assembled little-endian instruction
//   inst_pc_o     PC the instruction was fetched from
module if_fetch #(
  parameter int InstAddrW = 32,
  parameter int InstW     = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [1:0]           stall,
  input  logic                 branch,
  input  logic [InstAddrW-1:0] pc_i,
  output logic [InstAddrW-1:0] pc_next_o,
  output logic                 mem_req,
  output logic [InstAddrW-1:0] mem_addr,
  input  logic                 mem_ack,
  input  logic [7:0]           mem_data,
  output logic                 stall_req_o,
  output logic                 inst_valid_o,
  output logic [InstW-1:0]     inst_o,
  output logic [InstAddrW-1:0] inst_pc_o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_DONE,
    S_DRAIN
  } state_t;

  localparam logic [1:0] StPass = 2'b00;
  localparam logic [1:0] StBubb = 2'b10;

  state_t                 r_state;
  logic [1:0]             r_idx;
  logic [InstAddrW-1:0]   r_fetch_pc;
  logic                   r_mem_req;
  logic [InstAddrW-1:0]   r_mem_addr;
  logic [InstW-9:0]       r_buf;
  logic [InstW-1:0]       r_inst;
  logic [InstAddrW-1:0]   r_inst_pc;
  logic                   r_valid;

  logic                   w_idle_go;
  logic                   w_done_go;
  logic                   w_capture;
  logic [InstAddrW-1:0]   w_next_addr;

  // A Pass in DONE consumes the instruction and starts the
  // next fetch on the same edge, exactly as IDLE would.
  assign w_idle_go = (r_state == S_IDLE)
                  && (stall != StBubb);
  assign w_done_go = (r_state == S_DONE)
                  && (stall == StPass);
  assign w_capture = !branch
                  && (w_idle_go || w_done_go);

  // Address of the byte after the one being acked.
  assign w_next_addr = r_fetch_pc
                     + InstAddrW'(r_idx)
                     + InstAddrW'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_idx      <= 2'd0;
      r_fetch_pc <= '0;
      r_mem_req  <= 1'b0;
      r_mem_addr <= '0;
      r_buf      <= '0;
      r_inst     <= '0;
      r_inst_pc  <= '0;
      r_valid    <= 1'b0;
    end else if (branch) begin
      // Flush wins over everything. A request the memory
      // has not acked yet must still be drained so its
      // late ack is not taken for a new fetch.
      r_valid <= 1'b0;
      r_idx   <= 2'd0;
      if (r_mem_req && !mem_ack) begin
        r_state <= S_DRAIN;
      end else begin
        r_state   <= S_IDLE;
        r_mem_req <= 1'b0;
      end
    end else if (w_capture) begin
      r_fetch_pc <= pc_i;
      r_idx      <= 2'd0;
      r_mem_req  <= 1'b1;
      r_mem_addr <= pc_i;
      r_valid    <= 1'b0;
      r_state    <= S_FETCH;
    end else begin
      unique case (r_state)
        S_IDLE: begin
        end
        S_FETCH: begin
          if (mem_ack) begin
            r_idx      <= r_idx + 2'd1;
            r_mem_addr <= w_next_addr;
            unique case (r_idx)
              2'd0: r_buf[7:0]   <= mem_data;
              2'd1: r_buf[15:8]  <= mem_data;
              2'd2: r_buf[23:16] <= mem_data;
              2'd3: begin
                r_inst    <= {mem_data, r_buf};
                r_inst_pc <= r_fetch_pc;
                r_valid   <= 1'b1;
                r_mem_req <= 1'b0;
                r_state   <= S_DONE;
              end
            endcase
          end
        end
        S_DONE: begin
          if (stall == StBubb) begin
            r_valid <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        S_DRAIN: begin
          if (mem_ack) begin
            r_mem_req <= 1'b0;
            r_state   <= S_IDLE;
          end
        end
      endcase
    end
  end

  assign pc_next_o    = r_fetch_pc
                      + InstAddrW'(InstW / 8);
  assign mem_req      = r_mem_req;
  assign mem_addr     = r_mem_addr;
  assign stall_req_o  = (r_state == S_FETCH)
                     || (r_state == S_DRAIN);
  assign inst_valid_o = r_valid;
  assign inst_o       = r_inst;
  assign inst_pc_o    = r_inst_pc;

endmodule

// File: tb/tb_if_fetch.sv
// tb_if_fetch: directed and randomized bench for if_fetch
// with a byte-queue reference model and a behavioural memory.
module tb_if_fetch;

  localparam logic [1:0] PASS = 2'b00;
  localparam logic [1:0] HOLD = 2'b01;
  localparam logic [1:0] BUBB = 2'b10;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [1:0]  stall = BUBB;
  logic        branch = 1'b0;
  logic [31:0] pc_i = 32'h0;
  logic [31:0] pc_next_o;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [7:0]  mem_data;
  logic        stall_req_o;
  logic        inst_valid_o;
  logic [31:0] inst_o;
  logic [31:0] inst_pc_o;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  if_fetch #(
    .InstAddrW(32),
    .InstW(32)
  ) u_dut (
    .clk(clk),
    .rst(rst),
    .stall(stall),
    .branch(branch),
    .pc_i(pc_i),
    .pc_next_o(pc_next_o),
    .mem_req(mem_req),
    .mem_addr(mem_addr),
    .mem_ack(mem_ack),
    .mem_data(mem_data),
    .stall_req_o(stall_req_o),
    .inst_valid_o(inst_valid_o),
    .inst_o(inst_o),
    .inst_pc_o(inst_pc_o)
  );

  task automatic chk(input string tag,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h @%0t",
               tag, act, exp, $time);
    end
  endtask

  // ---------------- memory ----------------
  logic [7:0] mb [256];
  bit         zw    = 1'b1;
  bit         mhold = 1'b0;
  bit         spur  = 1'b0;
  logic       mack  = 1'b0;
  logic [7:0] mdat  = 8'h0;
  int         wcnt  = 0;

  assign mem_ack  = mack | spur;
  assign mem_data = mdat;

  function automatic int new_wait();
    return zw ? 0 : int'($urandom_range(0, 2));
  endfunction

  // Each ack retires one request; the next negedge with
  // mem_req still high is a fresh request.
  always @(negedge clk) begin
    #1;
    if (rst || !mem_req) begin
      mack = 1'b0;
      wcnt = new_wait();
    end else if (mhold) begin
      mack = 1'b0;
    end else begin
      if (mack) wcnt = new_wait();
      if (wcnt == 0) begin
        mack = 1'b1;
        mdat = mb[mem_addr[7:0]];
      end else begin
        mack = 1'b0;
        wcnt--;
      end
    end
  end

  function automatic logic [31:0] ref_word(
      input logic [31:0] a);
    logic [31:0] a1, a2, a3;
    a1 = a + 32'd1;
    a2 = a + 32'd2;
    a3 = a + 32'd3;
    return {mb[a3[7:0]], mb[a2[7:0]],
            mb[a1[7:0]], mb[a[7:0]]};
  endfunction

  // ------------- reference model -------------
  logic [7:0]  mq [$];
  logic [31:0] m_pc   = 32'h0;
  logic [31:0] m_addr = 32'h0;
  logic [31:0] m_inst = 32'h0;
  logic [31:0] m_ipc  = 32'h0;
  bit          m_req   = 1'b0;
  bit          m_drain = 1'b0;
  bit          m_valid = 1'b0;

  task automatic m_start();
    m_pc    = pc_i;
    m_addr  = pc_i;
    m_req   = 1'b1;
    m_drain = 1'b0;
    m_valid = 1'b0;
    mq.delete();
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_pc = 0; m_addr = 0; m_inst = 0; m_ipc = 0;
      m_req = 0; m_drain = 0; m_valid = 0;
      mq.delete();
    end else if (branch) begin
      m_valid = 1'b0;
      mq.delete();
      if (m_req && !mem_ack) m_drain = 1'b1;
      else begin
        m_req   = 1'b0;
        m_drain = 1'b0;
      end
    end else if (m_drain) begin
      if (mem_ack) begin
        m_req   = 1'b0;
        m_drain = 1'b0;
      end
    end else if (m_req) begin
      if (mem_ack) begin
        mq.push_back(mem_data);
        if (mq.size() == 4) begin
          m_inst  = {mq[3], mq[2], mq[1], mq[0]};
          m_ipc   = m_pc;
          m_valid = 1'b1;
          m_req   = 1'b0;
        end else begin
          m_addr = m_pc + 32'(mq.size());
        end
      end
    end else if (m_valid) begin
      if (stall == PASS) m_start();
      else if (stall == BUBB) m_valid = 1'b0;
    end else if (stall != BUBB) begin
      m_start();
    end
  end

  always @(negedge clk) begin
    chk("m_valid", inst_valid_o, m_valid);
    chk("m_req", mem_req, m_req);
    chk("m_sreq", stall_req_o, m_req);
    chk("m_pcnext", pc_next_o, m_pc + 32'd4);
    if (m_req) chk("m_addr", mem_addr, m_addr);
    chk("m_inst", inst_o, m_inst);
    chk("m_ipc", inst_pc_o, m_ipc);
    if (m_valid) chk("m_word", inst_o, ref_word(m_ipc));
  end

  // ---------------- stimulus ----------------
  task automatic chk_reset_vals(input string t);
    chk({t, "_req"}, mem_req, 0);
    chk({t, "_addr"}, mem_addr, 0);
    chk({t, "_v"}, inst_valid_o, 0);
    chk({t, "_inst"}, inst_o, 0);
    chk({t, "_ipc"}, inst_pc_o, 0);
    chk({t, "_sreq"}, stall_req_o, 0);
    chk({t, "_pcn"}, pc_next_o, 32'd4);
  endtask

  initial begin
    int r;
    for (int i = 0; i < 256; i++) mb[i] = 8'($urandom);
    mb[8'h00] = 8'h13;
    mb[8'h01] = 8'h05;
    mb[8'h02] = 8'h10;
    mb[8'h03] = 8'h00;
    mb[8'hFE] = 8'hAA;
    mb[8'hFF] = 8'hBB;

    #1 rst = 1'b1;
    @(negedge clk);
    chk_reset_vals("rst");

    // basic fetch, zero-wait memory
    rst = 1'b0; pc_i = 32'h1000; stall = PASS;
    for (int n = 1; n <= 5; n++) begin
      @(negedge clk);
      if (n < 5) begin
        chk("lat_v", inst_valid_o, 0);
        chk("f1_addr", mem_addr, 32'h1000 + n - 1);
      end
      if (n == 4) stall = HOLD;
    end
    chk("lat_v5", inst_valid_o, 1);
    chk("f1_inst", inst_o, 32'h0010_0513);
    chk("f1_ipc", inst_pc_o, 32'h1000);
    chk("f1_pcn", pc_next_o, 32'h1004);
    chk("f1_req", mem_req, 0);

    // hold three cycles in DONE
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("hold_v", inst_valid_o, 1);
      chk("hold_inst", inst_o, 32'h0010_0513);
      chk("hold_req", mem_req, 0);
    end
    pc_i = 32'h2000; stall = PASS;
    @(negedge clk);
    chk("b2b_req", mem_req, 1);
    chk("b2b_addr", mem_addr, 32'h2000);
    chk("b2b_v", inst_valid_o, 0);
    chk("b2b_sreq", stall_req_o, 1);

    // branch with the third byte outstanding
    @(negedge clk);
    @(negedge clk);
    chk("br_addr", mem_addr, 32'h2002);
    mhold = 1'b1; branch = 1'b1; pc_i = 32'h3000;
    @(negedge clk);
    branch = 1'b0;
    chk("dr_sreq", stall_req_o, 1);
    chk("dr_req", mem_req, 1);
    chk("dr_addr", mem_addr, 32'h2002);
    chk("dr_v", inst_valid_o, 0);
    @(negedge clk);
    chk("dr_sreq2", stall_req_o, 1);
    mhold = 1'b0;
    @(negedge clk);
    chk("dr_done_req", mem_req, 0);
    chk("dr_done_sreq", stall_req_o, 0);
    chk("dr_done_v", inst_valid_o, 0);
    @(negedge clk);
    chk("nf_req", mem_req, 1);
    chk("nf_addr", mem_addr, 32'h3000);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    stall = BUBB;
    @(negedge clk);
    chk("nf_v", inst_valid_o, 1);
    chk("nf_ipc", inst_pc_o, 32'h3000);

    // bubble in DONE
    @(negedge clk);
    chk("bub_v", inst_valid_o, 0);
    chk("bub_req", mem_req, 0);
    @(negedge clk);
    chk("bub_req2", mem_req, 0);

    // address wrap
    pc_i = 32'hFFFF_FFFE; stall = PASS;
    @(negedge clk);
    chk("wr_pcn", pc_next_o, 32'h0000_0002);
    chk("wr_a0", mem_addr, 32'hFFFF_FFFE);
    @(negedge clk);
    chk("wr_a1", mem_addr, 32'hFFFF_FFFF);
    @(negedge clk);
    chk("wr_a2", mem_addr, 32'h0000_0000);
    @(negedge clk);
    chk("wr_a3", mem_addr, 32'h0000_0001);
    stall = BUBB;
    @(negedge clk);
    chk("wr_v", inst_valid_o, 1);
    chk("wr_inst", inst_o, 32'h0513_BBAA);
    chk("wr_ipc", inst_pc_o, 32'hFFFF_FFFE);

    // async reset mid-fetch
    pc_i = 32'h1000; stall = PASS;
    @(negedge clk);
    chk("ar_req", mem_req, 1);
    #2 rst = 1'b1;
    #1 chk_reset_vals("arst");
    @(negedge clk);
    rst = 1'b0; stall = BUBB; spur = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("sp_req", mem_req, 0);
      chk("sp_v", inst_valid_o, 0);
      chk("sp_sreq", stall_req_o, 0);
    end
    spur = 1'b0;

    // randomized traffic
    zw = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      r = int'($urandom_range(0, 99));
      if (r < 60)      stall = PASS;
      else if (r < 75) stall = HOLD;
      else if (r < 90) stall = BUBB;
      else             stall = 2'b11;
      branch = ($urandom_range(0, 11) == 0);
      pc_i   = $urandom;
    end
    branch = 1'b0;
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
